// File: rtl/subtractor_32bit_seq.sv
// Multi-cycle subtractor: Diff = A - B - Bin, CHUNK bits per clock, LSB chunk first,
// with the borrow carried between cycles and valid/ready handshakes on both sides.
module subtractor_32bit_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Zero,
  output logic             Neg,
  output logic             Ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LSB_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic [IDX_W-1:0]   r_idx;
  logic               r_bout;
  logic               r_zero;
  logic               r_neg;
  logic               r_ovf;

  logic [LSB_W-1:0]   w_lsb;
  logic [CHUNK-1:0]   w_a_chunk;
  logic [CHUNK-1:0]   w_b_chunk;
  logic [CHUNK:0]     w_chunk;
  logic               w_last;
  logic [WIDTH-1:0]   w_diff_final;

  assign w_lsb     = LSB_W'(r_idx) * LSB_W'(CHUNK);
  assign w_a_chunk = r_a[w_lsb +: CHUNK];
  assign w_b_chunk = r_b[w_lsb +: CHUNK];
  // MSB of the CHUNK+1 bit result is the borrow into the next chunk
  assign w_chunk   = {1'b0, w_a_chunk} - {1'b0, w_b_chunk} - {{CHUNK{1'b0}}, r_borrow};
  assign w_last    = (r_idx == IDX_W'(NCHUNK - 1));

  // Diff with the current chunk merged in, so flags see the complete final result
  always_comb begin
    w_diff_final = r_diff;
    w_diff_final[w_lsb +: CHUNK] = w_chunk[CHUNK-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_state_next = S_RUN;
        else          w_state_next = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
        else        w_state_next = S_RUN;
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
        else           w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_RUN:   in_ready  = 1'b0;
      S_DONE:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand capture, per-chunk subtraction and final flag registration
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= Bin;
            r_idx    <= '0;
            r_diff   <= '0;
          end
        end
        S_RUN: begin
          r_diff   <= w_diff_final;
          r_borrow <= w_chunk[CHUNK];
          r_idx    <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_bout <= w_chunk[CHUNK];
            r_zero <= (w_diff_final == '0);
            r_neg  <= w_diff_final[WIDTH-1];
            r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                      (w_diff_final[WIDTH-1] != r_a[WIDTH-1]);
          end
        end
        S_DONE: begin
          r_diff <= r_diff;
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  assign Diff = r_diff;
  assign Bout = r_bout;
  assign Zero = r_zero;
  assign Neg  = r_neg;
  assign Ovf  = r_ovf;

endmodule

// File: tb/tb_subtractor_32bit_seq.sv
// Self-checking bench for subtractor_32bit_seq: directed vector table, handshake
// corner sequences and randomized operations against an arithmetic reference model.
module tb_subtractor_32bit_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Diff;
  logic        Bout;
  logic        Zero;
  logic        Neg;
  logic        Ovf;

  int tests = 0;
  int fails = 0;

  subtractor_32bit_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .Bout(Bout), .Zero(Zero), .Neg(Neg), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bo;
    logic        z;
    logic        n;
    logic        o;
  } vec_t;

  vec_t vecs [7];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference: full-width arithmetic on 33 bits, flags straight from their definitions
  task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                           output logic [31:0] d, output logic bo, output logic z,
                           output logic n, output logic o);
    logic [32:0] full;
    full = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    d  = full[31:0];
    bo = ({1'b0, a} < ({1'b0, b} + {32'd0, bin}));
    z  = (d == 32'd0);
    n  = d[31];
    o  = (a[31] != b[31]) && (d[31] != a[31]);
  endtask

  // Accept one operand set and wait (bounded) for the result; leaves out_ready low
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        output int lat, output bit ok);
    int k;
    k = 0;
    ok = 1'b1;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    check1("in_ready_before_accept", in_ready, 1'b1);
    A = a;
    B = b;
    Bin = bin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      check1("out_valid_timeout", out_valid, 1'b1);
      ok = 1'b0;
      do_reset();
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit ok;
    logic [31:0] ed;
    logic ebo, ez, en, eo;
    logic [31:0] ra, rb;
    logic rbin;
    int hold;

    vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h12345678, 32'h12345677, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1};

    A = 32'd0;
    B = 32'd0;
    Bin = 1'b0;
    do_reset();

    check1("reset_in_ready", in_ready, 1'b1);
    check1("reset_out_valid", out_valid, 1'b0);
    check32("reset_diff", Diff, 32'd0);
    check1("reset_bout", Bout, 1'b0);
    check1("reset_zero", Zero, 1'b0);
    check1("reset_neg", Neg, 1'b0);
    check1("reset_ovf", Ovf, 1'b0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, ok);
      if (ok) begin
        check32("vec_latency", 32'(lat), 32'd4);
        check32("vec_diff", Diff, vecs[i].d);
        check1("vec_bout", Bout, vecs[i].bo);
        check1("vec_zero", Zero, vecs[i].z);
        check1("vec_neg", Neg, vecs[i].n);
        check1("vec_ovf", Ovf, vecs[i].o);
        finish_op();
        check1("vec_in_ready_after", in_ready, 1'b1);
        check1("vec_out_valid_after", out_valid, 1'b0);
      end
    end

    // Backpressure: result held while new operands are offered and ignored
    run_op(32'd10, 32'd4, 1'b0, lat, ok);
    if (ok) begin
      A = 32'h0000DEAD;
      B = 32'h00000001;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
        tick();
        check32("bp_diff_stable", Diff, 32'd6);
        check1("bp_in_ready", in_ready, 1'b0);
        check1("bp_out_valid", out_valid, 1'b1);
        check1("bp_zero_stable", Zero, 1'b0);
      end
      in_valid = 1'b0;
      finish_op();
      check1("bp_in_ready_after", in_ready, 1'b1);
      check1("bp_out_valid_after", out_valid, 1'b0);
      check32("bp_diff_held", Diff, 32'd6);
    end

    // Reset while RUN is at idx 2
    A = 32'h11111111;
    B = 32'h00000001;
    Bin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check1("midrun_busy", in_ready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("midrun_reset_in_ready", in_ready, 1'b1);
    check1("midrun_reset_out_valid", out_valid, 1'b0);
    check32("midrun_reset_diff", Diff, 32'd0);
    run_op(32'd7, 32'd7, 1'b0, lat, ok);
    if (ok) begin
      check32("after_reset_latency", 32'(lat), 32'd4);
      check32("after_reset_diff", Diff, 32'd0);
      check1("after_reset_zero", Zero, 1'b1);
      finish_op();
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      ra = $urandom();
      rb = $urandom();
      rbin = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: ra = 32'($urandom_range(0, 3));
        default: ra = ra;
      endcase
      hold = $urandom_range(0, 2);
      ref_model(ra, rb, rbin, ed, ebo, ez, en, eo);
      run_op(ra, rb, rbin, lat, ok);
      if (ok) begin
        for (int c = 0; c < hold; c++) tick();
        check32("rand_latency", 32'(lat), 32'd4);
        check32("rand_diff", Diff, ed);
        check1("rand_bout", Bout, ebo);
        check1("rand_zero", Zero, ez);
        check1("rand_neg", Neg, en);
        check1("rand_ovf", Ovf, eo);
        finish_op();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
